depadding: RTL and testbench

DEPADDING -- requirements
Module: depadding

---
 rtl/depadding_pkg.sv | 7 +
 rtl/depadding_if.sv | 34 +++
 rtl/depadding_sync_fifo.sv | 80 ++++++++
 rtl/depadding.sv | 90 +++++++++
 tb/tb_depadding.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/depadding_pkg.sv
// Shared network defaults for the depadding block: element width and channel count.
package depadding_pkg;

  localparam int NN_N       = 8;
  localparam int NN_CHANNEL = 3;

endpackage

// File: rtl/depadding_if.sv
// Stream bundle for depadding: padded input stream in, cropped stream out.
interface depadding_if #(
  parameter int W = depadding_pkg::NN_N * depadding_pkg::NN_CHANNEL
);

  logic         input_vld;
  logic [W-1:0] input_din;
  logic         input_rdy;
  logic [W-1:0] crop_dout;
  logic         crop_dout_vld;
  logic         crop_dout_rdy;
  logic         crop_dout_end;

  modport slave (
    input  input_vld,
    input  input_din,
    output input_rdy,
    output crop_dout,
    output crop_dout_vld,
    input  crop_dout_rdy,
    output crop_dout_end
  );

  modport master (
    output input_vld,
    output input_din,
    input  input_rdy,
    input  crop_dout,
    input  crop_dout_vld,
    output crop_dout_rdy,
    input  crop_dout_end
  );

endinterface

// File: rtl/depadding_sync_fifo.sv
// Synchronous FIFO with a registered head stage; count_o covers the storage array only.
module sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   vld_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;

  logic wr_en, rd_en, out_free, take_mem, bypass, mem_wr;

  assign wr_en    = push_i & (count_q != FULL);
  assign rd_en    = pop_i & vld_q;
  assign out_free = ~vld_q | rd_en;
  assign take_mem = out_free & (count_q != '0);
  // An empty array lets a push land straight in the head register (1-cycle latency).
  assign bypass   = out_free & (count_q == '0) & wr_en;
  assign mem_wr   = wr_en & ~bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(mem_wr) - CW'(take_mem);
    dout_d   = dout_q;
    vld_d    = vld_q;
    if (mem_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (take_mem) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q];
      vld_d    = 1'b1;
    end else if (bypass) begin
      dout_d = din_i;
      vld_d  = 1'b1;
    end else if (out_free) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
    end
  end

  assign dout_o  = dout_q;
  assign vld_o   = vld_q;
  assign count_o = count_q;

endmodule

// File: rtl/depadding.sv
// Strips a PADDING-wide border from a raster-ordered PS x PS frame, emitting the SIZE x SIZE interior.
module depadding
  import depadding_pkg::*;
#(
  parameter int N          = NN_N,
  parameter int CHANNEL    = NN_CHANNEL,
  parameter int SIZE       = 32,
  parameter int PADDING    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  input logic        ce,
  depadding_if.slave bus
);

  localparam int W   = CHANNEL * N;
  localparam int PS  = SIZE + 2 * PADDING;
  localparam int CW  = (PS > 1) ? $clog2(PS) : 1;
  localparam int CW1 = CW + 1;
  localparam int FW  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0]  EDGE_MAX  = CW'(PS - 1);
  localparam logic [CW-1:0]  LAST_IDX  = CW'(PADDING + SIZE - 1);
  localparam logic [CW1-1:0] PAD_W     = CW1'(PADDING);
  localparam logic [CW1-1:0] SIZE_W    = CW1'(SIZE);
  localparam logic [FW-1:0]  FIFO_FULL = FW'(FIFO_DEPTH);

  logic [CW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic [CW1-1:0] row_off, col_off;
  logic           in_xfer, interior, last_beat, push, pop;
  logic [FW-1:0]  fifo_count;
  logic [W:0]     fifo_dout;
  logic           fifo_vld;

  assign bus.input_rdy = ce & (fifo_count < FIFO_FULL);
  assign in_xfer       = bus.input_vld & bus.input_rdy;

  // Offsets below the border wrap to large unsigned values, so one compare covers both bounds.
  assign row_off   = {1'b0, row_q} - PAD_W;
  assign col_off   = {1'b0, col_q} - PAD_W;
  assign interior  = (row_off < SIZE_W) & (col_off < SIZE_W);
  assign last_beat = (row_q == LAST_IDX) & (col_q == LAST_IDX);

  assign push = in_xfer & interior;
  assign pop  = ce & fifo_vld & bus.crop_dout_rdy;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (in_xfer) begin
      if (col_q == EDGE_MAX) begin
        col_d = '0;
        row_d = (row_q == EDGE_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  sync_fifo #(
    .WIDTH (W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({last_beat, bus.input_din}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .vld_o   (fifo_vld),
    .count_o (fifo_count)
  );

  assign bus.crop_dout     = fifo_dout[W-1:0];
  assign bus.crop_dout_vld = fifo_vld;
  assign bus.crop_dout_end = fifo_vld & fifo_dout[W];

endmodule

// File: tb/tb_depadding.sv
// Bench for depadding: directed tables/sequences plus a queue-based frame model checked every cycle.
module tb_depadding;

  localparam int W     = 24;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst, ce, vld, dout_rdy, sel;
  logic [W-1:0] din;
  bit           chk_en = 0, rand_rdy = 0, rand_ce = 0;
  int           n_cmp = 0, n_fail = 0;

  depadding_if #(.W(W)) ifa ();
  depadding_if #(.W(W)) ifb ();

  assign ifa.input_vld     = vld & ~sel;
  assign ifa.input_din     = din;
  assign ifa.crop_dout_rdy = dout_rdy;
  assign ifb.input_vld     = vld & sel;
  assign ifb.input_din     = din;
  assign ifb.crop_dout_rdy = dout_rdy;

  depadding #(.N(8), .CHANNEL(3), .SIZE(4), .PADDING(1), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk (clk), .rst (rst), .ce (ce), .bus (ifa.slave)
  );
  depadding #(.N(8), .CHANNEL(3), .SIZE(3), .PADDING(0), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk (clk), .rst (rst), .ce (ce), .bus (ifb.slave)
  );

  always #5 clk = ~clk;

  logic         cur_rdy, cur_vld, cur_end;
  logic [W-1:0] cur_dout;
  assign cur_rdy  = sel ? ifb.input_rdy     : ifa.input_rdy;
  assign cur_vld  = sel ? ifb.crop_dout_vld : ifa.crop_dout_vld;
  assign cur_end  = sel ? ifb.crop_dout_end : ifa.crop_dout_end;
  assign cur_dout = sel ? ifb.crop_dout     : ifa.crop_dout;

  typedef struct packed {
    logic [W-1:0] d;
    logic         last;
  } ent_t;

  ent_t mq[$];
  ent_t got[$];
  int   bidx = 0;
  int   il[16] = '{7, 8, 9, 10, 13, 14, 15, 16, 19, 20, 21, 22, 25, 26, 27, 28};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: buffered interior beats in a queue; capacity is the array plus the head register.
  always @(posedge clk) begin : model
    int  r, c, pad, size, ps;
    bit  acc, popd;
    pad  = sel ? 0 : 1;
    size = sel ? 3 : 4;
    ps   = size + 2 * pad;
    if (rst) begin
      mq.delete();
      bidx = 0;
    end else if (ce) begin
      acc  = vld && (mq.size() < DEPTH + 1);
      popd = dout_rdy && (mq.size() > 0);
      if (popd) void'(mq.pop_front());
      if (acc) begin
        r = bidx / ps;
        c = bidx % ps;
        if (r >= pad && r < pad + size && c >= pad && c < pad + size)
          mq.push_back('{d: din, last: (r == pad + size - 1 && c == pad + size - 1)});
        bidx = (bidx + 1) % (ps * ps);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("sb_rdy", 32'(cur_rdy), 32'(ce && (mq.size() < DEPTH + 1)));
      check("sb_vld", 32'(cur_vld), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("sb_dout", 32'(cur_dout), 32'(mq[0].d));
        check("sb_end", 32'(cur_end), 32'(mq[0].last));
      end else begin
        check("sb_end_idle", 32'(cur_end), 32'd0);
      end
    end
    if (!rst && ce && cur_vld && dout_rdy) got.push_back('{d: cur_dout, last: cur_end});
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) dout_rdy = 1'($urandom_range(0, 1));
    if (rand_ce) ce = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive_beat(input logic [W-1:0] v, input int budget);
    bit ok = 0;
    vld = 1'b1;
    din = v;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      ok = cur_rdy;
      tick();
      if (ok) break;
    end
    if (!ok) check("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_got(input string name, input int n, input int budget);
    for (int t = 0; t < budget && got.size() < n; t++) tick();
    check(name, got.size(), n);
  endtask

  // Expected outputs are the listed interior values of a 0..35 frame, shifted per frame.
  task automatic check_frames(input string name, input int base0, input int nframes);
    int ends = 0;
    check({name, "_count"}, got.size(), 16 * nframes);
    for (int i = 0; i < got.size() && i < 16 * nframes; i++) begin
      check({name, "_data"}, 32'(got[i].d), 32'(il[i % 16] + base0 + 36 * (i / 16)));
      check({name, "_end"}, 32'(got[i].last), 32'((i % 16) == 15));
      if (got[i].last) ends++;
    end
    check({name, "_nends"}, ends, nframes);
  endtask

  typedef struct {
    logic [W-1:0] din;
    bit           vin;
    bit           ev;
    logic [W-1:0] ed;
    bit           ee;
  } vec_t;

  vec_t vec[37];

  initial begin
    logic [W-1:0] sd;
    logic         sv, se;

    for (int k = 0; k < 37; k++) begin
      vec[k].din = W'(k);
      vec[k].vin = (k < 36);
      vec[k].ev  = 0;
      vec[k].ed  = '0;
      vec[k].ee  = 0;
      for (int j = 0; j < 16; j++) begin
        if (k - 1 == il[j]) begin
          vec[k].ev = 1;
          vec[k].ed = W'(k - 1);
          vec[k].ee = (il[j] == 28);
        end
      end
    end

    sel = 1'b0; rst = 1'b1; ce = 1'b1; vld = 1'b0; din = '0; dout_rdy = 1'b1;
    tick();
    chk_en = 1;
    tick();
    @(negedge clk);
    check("reset_vld", 32'(cur_vld), 32'd0);
    check("reset_end", 32'(cur_end), 32'd0);
    check("reset_dout", 32'(cur_dout), 32'd0);
    check("reset_rdy", 32'(cur_rdy), 32'd1);
    tick();
    rst = 1'b0;

    // Back-to-back frame, output visible one cycle after each interior input
    for (int k = 0; k < 37; k++) begin
      vld = vec[k].vin;
      din = vec[k].din;
      @(negedge clk);
      check("tbl_rdy", 32'(cur_rdy), 32'd1);
      check("tbl_vld", 32'(cur_vld), 32'(vec[k].ev));
      check("tbl_end", 32'(cur_end), 32'(vec[k].ee));
      if (vec[k].ev) check("tbl_dout", 32'(cur_dout), 32'(vec[k].ed));
      tick();
    end
    vld = 1'b0;

    // Full backpressure: beat 13 fits, beat 14 stalls
    got.delete();
    dout_rdy = 1'b0;
    for (int v = 0; v < 14; v++) drive_beat(W'(v), 4);
    din = W'(14);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_rdy", 32'(cur_rdy), 32'd0);
      check("stall_head", 32'(cur_dout), 32'd7);
      tick();
    end
    dout_rdy = 1'b1;
    for (int v = 14; v < 36; v++) drive_beat(W'(v), 10);
    vld = 1'b0;
    wait_got("bp_drain", 16, 50);
    check_frames("bp", 0, 1);

    // ce low for five cycles after beat 15
    got.delete();
    for (int v = 0; v < 16; v++) drive_beat(W'(v), 10);
    ce = 1'b0;
    din = W'(16);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        sd = cur_dout; sv = cur_vld; se = cur_end;
        check("ce_head", 32'(sd), 32'd15);
        check("ce_head_vld", 32'(sv), 32'd1);
      end else begin
        check("ce_frz_dout", 32'(cur_dout), 32'(sd));
        check("ce_frz_vld", 32'(cur_vld), 32'(sv));
        check("ce_frz_end", 32'(cur_end), 32'(se));
      end
      check("ce_rdy", 32'(cur_rdy), 32'd0);
      tick();
    end
    ce = 1'b1;
    for (int v = 16; v < 36; v++) drive_beat(W'(v), 10);
    vld = 1'b0;
    wait_got("ce_drain", 16, 50);
    check_frames("ce", 0, 1);

    // Reset mid-frame, then a fresh frame 100..135
    for (int v = 0; v < 21; v++) drive_beat(W'(v), 10);
    vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got.delete();
    @(negedge clk);
    check("rst_mid_vld", 32'(cur_vld), 32'd0);
    check("rst_mid_end", 32'(cur_end), 32'd0);
    check("rst_mid_dout", 32'(cur_dout), 32'd0);
    tick();
    for (int v = 100; v < 136; v++) drive_beat(W'(v), 10);
    vld = 1'b0;
    wait_got("rst_drain", 16, 50);
    check_frames("rst", 100, 1);

    // Two frames with random output backpressure
    got.delete();
    rand_rdy = 1;
    for (int v = 0; v < 72; v++) drive_beat(W'(v), 20);
    vld = 1'b0;
    wait_got("two_drain", 32, 300);
    rand_rdy = 0;
    dout_rdy = 1'b1;
    check_frames("two", 0, 2);

    // Random soak: random data, input gaps, ce and backpressure
    got.delete();
    rand_rdy = 1;
    rand_ce  = 1;
    for (int v = 0; v < 108; v++) begin
      vld = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      drive_beat(W'($urandom), 50);
    end
    vld = 1'b0;
    rand_rdy = 0;
    rand_ce  = 0;
    ce = 1'b1;
    dout_rdy = 1'b1;
    wait_got("soak_drain", 48, 100);

    // PADDING=0 instance: pure pass-through
    rst = 1'b1;
    tick();
    sel = 1'b1;
    tick();
    rst = 1'b0;
    got.delete();
    for (int v = 0; v < 9; v++) drive_beat(W'(200 + v), 10);
    vld = 1'b0;
    wait_got("pass_drain", 9, 30);
    for (int i = 0; i < got.size() && i < 9; i++) begin
      check("pass_data", 32'(got[i].d), 32'(200 + i));
      check("pass_end", 32'(got[i].last), 32'(i == 8));
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
